// File: rtl/ahb_mem_slave_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ahb_mem_slave_gen_if                                       |
// | Purpose : AHB-Lite bus bundle between an interconnect/master and     |
// |           the ahb_mem_slave_gen memory slave.                        |
// | Ports   : none; the signals below are carried by the interface.      |
// |           master modport drives the address/data phase and HREADY,   |
// |           slave modport drives HREADYOUT/HRESP/HRDATA.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface ahb_mem_slave_gen_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [1:0]        HTRANS;
   logic [DATA_W-1:0] HWDATA;
   logic              HREADY;
   logic              HREADYOUT;
   logic              HRESP;
   logic [DATA_W-1:0] HRDATA;

   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface
`default_nettype wire

// File: rtl/ahb_mem_slave_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ahb_mem_slave_gen                                          |
// | Purpose : Pipelined AHB-Lite slave in front of a single-port         |
// |           synchronous RAM (1-cycle read latency). Supports reads,    |
// |           byte/halfword/word writes, programmable wait states,       |
// |           address window decode and two-cycle ERROR responses.       |
// | Ports   : HCLK, HRESET (sync, active high)                           |
// |           bus        - AHB-Lite slave modport                        |
// |           cfg_enable - 0 forces ERROR on every active transfer       |
// |           mem_*      - RAM port (addr, we, re, be, wdata, rdata)     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ahb_mem_slave_gen #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] MEM_BASE    = '0,
   parameter int                MEM_SIZE    = 4096,
   parameter int                WAIT_STATES = 0,
   localparam int               c_nb        = DATA_W / 8,
   localparam int               c_mem_aw    = $clog2(MEM_SIZE / c_nb)
) (
   input  logic                HCLK,
   input  logic                HRESET,
   ahb_mem_slave_gen_if.slave  bus,
   input  logic                cfg_enable,
   output logic [c_mem_aw-1:0] mem_addr,
   output logic                mem_we,
   output logic                mem_re,
   output logic [c_nb-1:0]     mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int c_nb_log2 = $clog2(c_nb);
   localparam int c_off_w   = $clog2(MEM_SIZE);

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_wait = 3'd1;
   localparam logic [2:0] c_st_rd   = 3'd2;
   localparam logic [2:0] c_st_data = 3'd3;
   localparam logic [2:0] c_st_err1 = 3'd4;
   localparam logic [2:0] c_st_err2 = 3'd5;

   logic [2:0]          r_state;
   logic [2:0]          w_next;
   logic [2:0]          r_cnt;
   logic [c_mem_aw-1:0] r_addr;
   logic [c_nb-1:0]     r_be;
   logic                r_write;
   logic                r_seq_ok;
   logic                r_after_rd;
   logic [DATA_W-1:0]   r_rbuf;
   logic [DATA_W-1:0]   r_hrdata;

   logic                w_capture;
   logic                w_in_range;
   logic                w_size_bad;
   logic [c_nb_log2-1:0] w_lowmask;
   logic                w_misalign;
   logic                w_seq_bad;
   logic                w_err;
   logic [c_nb-1:0]     w_be_ones;
   logic [c_nb-1:0]     w_be;
   logic                w_hreadyout;
   logic                w_hresp;
   logic                w_mem_we;
   logic                w_mem_re;
   logic                w_rd_data;
   logic [DATA_W-1:0]   w_rdata_sel;
   logic                w_unused;

   // Burst type is informational only: every beat carries its own HADDR.
   assign w_unused = ^bus.HBURST;

   // ---------------------------------------------------------------
   // Address-phase decode
   // ---------------------------------------------------------------
   assign w_capture  = bus.HSEL & bus.HREADY & bus.HTRANS[1];
   // Window is aligned to its size, so matching the upper bits is enough.
   assign w_in_range = (bus.HADDR[ADDR_W-1:c_off_w] == MEM_BASE[ADDR_W-1:c_off_w]);
   assign w_size_bad = (bus.HSIZE > 3'(c_nb_log2));
   assign w_lowmask  = c_nb_log2'((32'd1 << bus.HSIZE) - 32'd1);
   assign w_misalign = |(bus.HADDR[c_nb_log2-1:0] & w_lowmask);
   assign w_seq_bad  = (bus.HTRANS == 2'b11) & ~r_seq_ok;
   assign w_err      = ~cfg_enable | ~w_in_range | w_size_bad | w_misalign | w_seq_bad;
   // 2^HSIZE byte lanes, placed at the byte offset inside the word.
   assign w_be_ones  = c_nb'((32'd1 << (32'd1 << bus.HSIZE)) - 32'd1);
   assign w_be       = w_be_ones << bus.HADDR[c_nb_log2-1:0];

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_rd: begin
            w_next = (WAIT_STATES == 0) ? c_st_data : c_st_wait;
         end
         c_st_wait: begin
            if (r_cnt == 3'd1) begin
               w_next = c_st_data;
            end
         end
         c_st_err1: begin
            w_next = c_st_err2;
         end
         default: begin
            // IDLE, DATA and ERR2 all end with HREADYOUT=1, so a new
            // address phase may be accepted here without an idle gap.
            if (w_capture) begin
               if (w_err) begin
                  w_next = c_st_err1;
               end else if (!bus.HWRITE) begin
                  w_next = c_st_rd;
               end else if (WAIT_STATES == 0) begin
                  w_next = c_st_data;
               end else begin
                  w_next = c_st_wait;
               end
            end else begin
               w_next = c_st_idle;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      w_hreadyout = 1'b1;
      w_hresp     = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      case (r_state)
         c_st_wait: begin
            w_hreadyout = 1'b0;
         end
         c_st_rd: begin
            w_hreadyout = 1'b0;
            w_mem_re    = 1'b1;
         end
         c_st_data: begin
            w_mem_we = r_write;
         end
         c_st_err1: begin
            w_hreadyout = 1'b0;
            w_hresp     = 1'b1;
         end
         c_st_err2: begin
            w_hresp = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_cnt      <= 3'd0;
         r_addr     <= '0;
         r_be       <= '0;
         r_write    <= 1'b0;
         r_seq_ok   <= 1'b0;
         r_after_rd <= 1'b0;
         r_rbuf     <= '0;
         r_hrdata   <= '0;
      end else begin
         if (w_capture & ~w_err) begin
            r_addr  <= bus.HADDR[c_off_w-1:c_nb_log2];
            r_be    <= w_be;
            r_write <= bus.HWRITE;
         end

         if ((w_next == c_st_wait) && (r_state != c_st_wait)) begin
            r_cnt <= 3'(WAIT_STATES);
         end else if (r_state == c_st_wait) begin
            r_cnt <= r_cnt - 3'd1;
         end

         // A SEQ is legal only right after an accepted NONSEQ/SEQ to this
         // slave; BUSY keeps the burst open, anything else closes it.
         if (bus.HREADY) begin
            if (bus.HSEL & bus.HTRANS[1]) begin
               r_seq_ok <= ~w_err;
            end else if (!(bus.HSEL && (bus.HTRANS == 2'b01))) begin
               r_seq_ok <= 1'b0;
            end
         end

         // RAM data is valid the cycle after mem_re; park it in case
         // wait states push the DATA cycle further out.
         r_after_rd <= (r_state == c_st_rd);
         if (r_after_rd) begin
            r_rbuf <= mem_rdata;
         end

         if (w_rd_data) begin
            r_hrdata <= w_rdata_sel;
         end
      end
   end

   assign w_rd_data   = (r_state == c_st_data) & ~r_write;
   assign w_rdata_sel = r_after_rd ? mem_rdata : r_rbuf;

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign bus.HREADYOUT = w_hreadyout;
   assign bus.HRESP     = w_hresp;
   assign bus.HRDATA    = w_rd_data ? w_rdata_sel : r_hrdata;

   assign mem_addr  = r_addr;
   assign mem_we    = w_mem_we;
   assign mem_re    = w_mem_re;
   assign mem_be    = w_mem_we ? r_be : '0;
   assign mem_wdata = w_mem_we ? bus.HWDATA : '0;

endmodule
`default_nettype wire
